// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter (plus package mem_bus_pkg)
//  Purpose  : Shares the single core-to-memory bus (cbus) between the
//             instruction-fetch port (ibus) and the load/store port (dbus).
//             Only one transaction is outstanding at a time. The winning
//             request is latched onto oreq and held until oresp reports
//             ready & last. The winner then receives a one-cycle response
//             pulse (DONE state).
//  Ports    : clk, rst (asynchronous, active-high)
//             ireq  / iresp : fetch request / response
//             dreq  / dresp : data request / response
//             oreq  / oresp : shared bus request / response
//             busy          : high while not IDLE
//  Params   : STARVE_LIMIT  : number of consecutive dbus grants made while
//                             ibus is pending before ibus is forced (1-15)
//  Options  : ARB_RR_EN     : when defined, ties are resolved round-robin
//                             and the starvation counter is held at 0
//  Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;
    localparam logic [2:0] MSIZE1          = 3'd0;
    localparam logic [2:0] MSIZE2          = 3'd1;
    localparam logic [2:0] MSIZE4          = 3'd2;
    localparam logic [2:0] MSIZE8          = 3'd3;
    localparam logic [7:0] MLEN1           = 8'd0;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Owner encoding: none / ibus / dbus
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_I    = 2'd1;
    localparam logic [1:0] c_OWN_D    = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    cbus_req_t   r_oreq;
    logic [63:0] r_rdata;
    logic [1:0]  r_owner;
    logic        w_pick_d;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_complete;

`ifdef ARB_RR_EN
    // Last granted port; starts as ibus so dbus wins the first tie.
    logic r_last_i;

    assign w_pick_d = dreq.valid && (!ireq.valid || r_last_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_i <= 1'b1;
        end else if (w_grant_i) begin
            r_last_i <= 1'b1;
        end else if (w_grant_d) begin
            r_last_i <= 1'b0;
        end
    end
`else
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // Consecutive dbus grants made while ibus was waiting.
    logic [3:0] r_starve_cnt;

    assign w_pick_d = dreq.valid && (!ireq.valid || (r_starve_cnt < c_STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d) begin
            if (!ireq.valid) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end
`endif

    assign w_complete = oresp.ready && oresp.last;

    // Next-state logic; grants are only evaluated in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (ireq.valid) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_complete) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched bus request; held constant for the whole BUSY phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oreq  <= '0;
            r_rdata <= 64'd0;
            r_owner <= c_OWN_NONE;
        end else if (w_grant_i) begin
            r_oreq.valid    <= 1'b1;
            r_oreq.is_write <= 1'b0;
            r_oreq.size     <= MSIZE4;
            r_oreq.addr     <= ireq.addr;
            r_oreq.strobe   <= 8'd0;
            r_oreq.data     <= 64'd0;
            r_oreq.len      <= MLEN1;
            r_oreq.burst    <= AXI_BURST_FIXED;
            r_owner         <= c_OWN_I;
        end else if (w_grant_d) begin
            r_oreq.valid    <= 1'b1;
            r_oreq.is_write <= |dreq.strobe;
            r_oreq.size     <= dreq.size;
            r_oreq.addr     <= dreq.addr;
            r_oreq.strobe   <= dreq.strobe;
            r_oreq.data     <= dreq.data;
            r_oreq.len      <= MLEN1;
            r_oreq.burst    <= AXI_BURST_FIXED;
            r_owner         <= c_OWN_D;
        end else if ((r_state == S_BUSY_I || r_state == S_BUSY_D) && w_complete) begin
            r_oreq.valid <= 1'b0;
            r_rdata      <= oresp.data;
        end else if (r_state == S_DONE) begin
            r_owner <= c_OWN_NONE;
        end
    end

    // Response pulse only in DONE; the latched addr selects the fetch word.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (r_state == S_DONE) begin
            if (r_owner == c_OWN_I) begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = r_oreq.addr[2] ? r_rdata[63:32] : r_rdata[31:0];
            end else if (r_owner == c_OWN_D) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = r_rdata;
            end
        end
    end

    assign oreq = r_oreq;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter.
//             The test selection follows ARB_RR_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic       clk;
    logic       rst;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;

    int n_cmp;
    int n_err;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for oreq.valid; leaves us at the first valid cycle.
    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oreq.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Completes the bus transaction now; returns in the DONE cycle.
    task automatic respond(input logic [63:0] rdata);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = rdata;
        tick();
        oresp = '0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (oreq !== '0) begin n_err++; $display("FAIL reset_oreq: got %h want 0", oreq); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (iresp !== '0 || dresp !== '0) begin n_err++; $display("FAIL reset_resp: got i=%h d=%h want 0", iresp, dresp); end
        rst = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_ibus_fetch();
        logic ok;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fetch_grant: got timeout want grant"); end
        ireq.valid = 1'b0;
        n_cmp++; if (oreq.addr !== 64'h8000_0004) begin n_err++; $display("FAIL fetch_addr: got %h want 80000004", oreq.addr); end
        n_cmp++; if (oreq.size !== MSIZE4 || oreq.is_write !== 1'b0 || oreq.strobe !== 8'd0) begin
            n_err++; $display("FAIL fetch_attr: got size=%0d wr=%b strb=%h want 2 0 00", oreq.size, oreq.is_write, oreq.strobe); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b want 1", busy); end
        respond(64'h1111_2222_3333_4444);
        n_cmp++; if (iresp.addr_ok !== 1'b1 || iresp.data_ok !== 1'b1) begin
            n_err++; $display("FAIL fetch_pulse: got a=%b d=%b want 1 1", iresp.addr_ok, iresp.data_ok); end
        n_cmp++; if (iresp.data !== 32'h1111_2222) begin n_err++; $display("FAIL fetch_data: got %h want 11112222", iresp.data); end
        n_cmp++; if (dresp.data_ok !== 1'b0) begin n_err++; $display("FAIL fetch_no_dresp: got %b want 0", dresp.data_ok); end
        n_cmp++; if (oreq.valid !== 1'b0) begin n_err++; $display("FAIL fetch_oreq_clear: got %b want 0", oreq.valid); end
        tick();
        n_cmp++; if (iresp.data_ok !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL fetch_one_cycle: got ok=%b busy=%b want 0 0", iresp.data_ok, busy); end
    endtask

    task automatic test_priority();
        logic ok;
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_0000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h100;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL prio_grant_d: got timeout want grant"); end
        dreq.valid = 1'b0;
        n_cmp++; if (oreq.is_write !== 1'b1 || oreq.addr !== 64'h100 || oreq.data !== 64'hDEAD) begin
            n_err++; $display("FAIL prio_dbus_first: got wr=%b addr=%h data=%h want 1 100 dead", oreq.is_write, oreq.addr, oreq.data); end
        respond(64'hCAFE_F00D_1234_5678);
        n_cmp++; if (dresp.data_ok !== 1'b1 || dresp.data !== 64'hCAFE_F00D_1234_5678) begin
            n_err++; $display("FAIL prio_dresp: got ok=%b data=%h want 1 cafef00d12345678", dresp.data_ok, dresp.data); end
        n_cmp++; if (iresp.data_ok !== 1'b0) begin n_err++; $display("FAIL prio_iresp_early: got %b want 0", iresp.data_ok); end
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL prio_grant_i: got timeout want grant"); end
        ireq.valid = 1'b0;
        n_cmp++; if (oreq.is_write !== 1'b0 || oreq.addr !== 64'h8000_0000) begin
            n_err++; $display("FAIL prio_ibus_second: got wr=%b addr=%h want 0 80000000", oreq.is_write, oreq.addr); end
        respond(64'h5555_6666_7777_8888);
        n_cmp++; if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h7777_8888) begin
            n_err++; $display("FAIL prio_iresp: got ok=%b data=%h want 1 77778888", iresp.data_ok, iresp.data); end
        tick();
    endtask

    // Runs six grants with both requesters continuously valid and checks
    // the owner sequence (1 = dbus, 0 = ibus).
    task automatic run_contention(input logic [5:0] exp_d, input string tag);
        logic ok;
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_0008;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h200;
        dreq.size   = MSIZE1;
        dreq.strobe = 8'h01;
        dreq.data   = 64'h1;
        for (int g = 0; g < 6; g++) begin
            wait_grant(ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL %s_grant%0d: got timeout want grant", tag, g); end
            n_cmp++; if (oreq.is_write !== exp_d[g]) begin
                n_err++; $display("FAIL %s_owner%0d: got dbus=%b want %b", tag, g, oreq.is_write, exp_d[g]); end
            respond(64'h0);
        end
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle: got busy=%b want 0", tag, busy); end
    endtask

`ifdef ARB_RR_EN
    task automatic test_round_robin();
        run_contention(6'b010101, "rr");
    endtask
`else
    task automatic test_starvation();
        // g0..g3 dbus, g4 forced ibus, g5 dbus again (counter cleared)
        run_contention(6'b101111, "starve");
    endtask
`endif

    task automatic test_hold();
        logic ok;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h300;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'h1234;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL hold_grant: got timeout want grant"); end
        dreq.valid = 1'b0;
        dreq.addr  = 64'h999;
        dreq.data  = 64'h5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (oreq.valid !== 1'b1 || oreq.addr !== 64'h300 || oreq.data !== 64'h1234 || oreq.strobe !== 8'h0F) begin
                n_err++; $display("FAIL hold_oreq%0d: got v=%b addr=%h data=%h strb=%h want 1 300 1234 0f",
                                  i, oreq.valid, oreq.addr, oreq.data, oreq.strobe); end
            n_cmp++; if (dresp.data_ok !== 1'b0) begin n_err++; $display("FAIL hold_early%0d: got %b want 0", i, dresp.data_ok); end
        end
        respond(64'hABCD);
        n_cmp++; if (dresp.data_ok !== 1'b1 || dresp.data !== 64'hABCD) begin
            n_err++; $display("FAIL hold_dresp: got ok=%b data=%h want 1 abcd", dresp.data_ok, dresp.data); end
        tick();
        n_cmp++; if (dresp.data_ok !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL hold_single: got ok=%b busy=%b want 0 0", dresp.data_ok, busy); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic stale;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h400;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h77;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmid_grant: got timeout want grant"); end
        dreq.valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (oreq.valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmid_abort: got v=%b busy=%b want 0 0", oreq.valid, busy); end
        n_cmp++; if (iresp !== '0 || dresp !== '0) begin
            n_err++; $display("FAIL rmid_resp: got i=%h d=%h want 0", iresp, dresp); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hBAD;
        tick();
        rst   = 1'b0;
        oresp = '0;
        stale = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dresp.data_ok !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got stale activity want none"); end
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0010;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1 || oreq.addr !== 64'h8000_0010 || oreq.is_write !== 1'b0) begin
            n_err++; $display("FAIL rmid_ibus: got ok=%b addr=%h wr=%b want 1 80000010 0", ok, oreq.addr, oreq.is_write); end
        ireq.valid = 1'b0;
        respond(64'h9999_0000_2222_3333);
        n_cmp++; if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h2222_3333 || dresp.data_ok !== 1'b0) begin
            n_err++; $display("FAIL rmid_iresp: got ok=%b data=%h dok=%b want 1 22223333 0", iresp.data_ok, iresp.data, dresp.data_ok); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ibus_fetch();
        test_priority();
`ifdef ARB_RR_EN
        test_round_robin();
`else
        test_starvation();
`endif
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core-to-memory bus (cbus) between the instruction-fetch port (ibus) and the load/store port (dbus).
- Sits between programCounter / memory stage and the top-level cbus; one outstanding transaction at a time.
- Latches the winning request, drives cbus until completion, then returns a one-cycle response pulse to the winner.
- Fixed dbus priority, with a starvation guard for ibus.

Parameters:
STARVE_LIMIT, 4, consecutive dbus grants while ibus pending before ibus is forced the next grant (range 1-15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ireq  input  ibus_req_t  fetch request (valid, addr[63:0])
iresp  output  ibus_resp_t  fetch response (addr_ok, data_ok, data[31:0])
dreq  input  dbus_req_t  data request (valid, addr, size, strobe[7:0], data[63:0])
dresp  output  dbus_resp_t  data response (addr_ok, data_ok, data[63:0])
oreq  output  cbus_req_t  shared bus request (valid, is_write, size, addr, strobe, data, len, burst)
oresp  input  cbus_resp_t  shared bus response (ready, last, data[63:0])
busy  output  1  high while a transaction is granted or completing

Behaviour:
- Reset (asynchronous, active-high): rst, asynchronous, active-high; clock clk. On reset: state=IDLE, oreq all fields 0, iresp/dresp all fields 0, busy=0, starve_cnt=0, owner=none. Reset mid-transaction aborts it; no response is issued.
- FSM: IDLE -> BUSY_I / BUSY_D -> DONE -> IDLE.
- IDLE:
  - Sample ireq.valid / dreq.valid.
  - Winner = dbus if dreq.valid and (not ireq.valid or starve_cnt < STARVE_LIMIT); otherwise ibus if ireq.valid.
  - On grant, register the winner's fields into oreq and set oreq.valid=1 at the next edge.
- Ibus grant mapping: is_write=0, size=MSIZE4, strobe=0, data=0, len=MLEN1, burst=AXI_BURST_FIXED, addr=ireq.addr.
- Dbus grant mapping: is_write=|dreq.strobe, size/addr/strobe/data copied from dreq, len=MLEN1, burst=AXI_BURST_FIXED.
- BUSY_x:
  - oreq held constant (latched copy); requester changes are ignored.
  - On oresp.ready & oresp.last: latch oresp.data, clear oreq.valid, go to DONE.
- DONE (exactly one cycle):
  - Winner's resp has addr_ok=1 and data_ok=1.
  - iresp.data = addr[2] ? rdata[63:32] : rdata[31:0], using the latched addr. dresp.data = rdata.
  - Next state is IDLE. No grant is evaluated in DONE, so a still-high valid is not re-granted before the requester drops it.
- Responses are 0 in every cycle other than DONE.
- Minimum latency: request at cycle 0 -> oreq.valid at cycle 1 -> (ready & last at cycle 1) -> response pulse at cycle 2.
- starve_cnt:
  - +1 (saturating at 15) on each dbus grant while ireq.valid=1.
  - Cleared on any ibus grant, and on a dbus grant while ireq.valid=0.
- Requester drops valid during BUSY: the transaction still completes and the DONE pulse is still issued.
- Simultaneous ireq.valid and dreq.valid in IDLE: resolved by the rule above; the loser waits, with no state change for it.
- busy = (state != IDLE).

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, the port not granted last wins (a last_owner flop, reset to ibus, so dbus wins the first tie). starve_cnt and STARVE_LIMIT are unused; starve_cnt is held at 0.
- Undefined: fixed dbus priority with the STARVE_LIMIT guard, as described above.

Test Plan:
- Reset, then ireq valid addr=0x8000_0004; oresp ready & last with data=0x1111_2222_3333_4444 one cycle after oreq.valid -> oreq.addr=0x8000_0004, size=MSIZE4, is_write=0. iresp pulse exactly 1 cycle with data=0x1111_2222.
- ireq and dreq valid together in IDLE (dreq strobe=0xFF, data=0xDEAD, addr=0x100) -> dbus granted first, oreq.is_write=1. After the dresp pulse, ibus granted; iresp arrives last.
- dreq held continuously valid, ireq valid, STARVE_LIMIT=4 -> exactly 4 dbus grants, then an ibus grant; starve_cnt back to 0 afterwards.
- oresp.ready delayed 5 cycles while dreq.addr/data change during BUSY -> oreq stays equal to the originally latched values; single dresp pulse after ready & last.
- rst asserted while in BUSY_D -> oreq.valid and all responses 0 immediately. Later ireq serviced normally, with no stale dresp pulse.
- With ARB_RR_EN: continuous simultaneous requests -> grants alternate D, I, D, I.
